// File: rtl/token_decoder_pkg.sv
// Shared types and constants for the token decoder (vocab index -> character stream).
package token_decoder_pkg;

  localparam int unsigned TERM_CHAR = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK_RD,
    S_SEEK_CHK,
    S_EMIT_RD,
    S_EMIT_CHK,
    S_EMIT_OUT
  } state_t;

endpackage

// File: rtl/token_decoder_if.sv
// Token, vocab SRAM and character-sink signals of the token decoder.
interface token_decoder_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tok_valid;
  logic                  tok_ready;
  logic [ADDR_WIDTH-1:0] tok_idx;
  logic                  mem_cs;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  ch_valid;
  logic                  ch_ready;
  logic [DATA_WIDTH-1:0] ch_data;
  logic                  ch_last;
  logic                  err_nf;

  modport master (
    input  tok_valid, tok_idx, mem_dout, ch_ready,
    output tok_ready, mem_cs, mem_addr, ch_valid, ch_data, ch_last, err_nf
  );

  modport slave (
    output tok_valid, tok_idx, mem_dout, ch_ready,
    input  tok_ready, mem_cs, mem_addr, ch_valid, ch_data, ch_last, err_nf
  );
endinterface

// File: rtl/token_decoder.sv
// Streams the characters of vocab word tok_idx out of a null-terminated vocab SRAM.
// Optional TOKDEC_CACHE_EN: remembers the start address of the last cleanly emitted word.
module token_decoder
  import token_decoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 15
) (
  input  logic            blocker_clk,
  input  logic            rst_n,
  token_decoder_if.master bus
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);
  localparam logic [DATA_WIDTH-1:0] TERM    = DATA_WIDTH'(TERM_CHAR);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] ch_data_q, ch_data_d;
  logic                  ch_last_q, ch_last_d;
  logic                  err_nf_q, err_nf_d;
  logic                  ch_valid_q, ch_valid_d;
  logic                  tok_ready_q, tok_ready_d;
  logic                  mem_cs_q, mem_cs_d;

  logic                  is_term;
  logic                  at_end;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  cache_hit;
  logic [ADDR_WIDTH-1:0] hit_addr;

`ifdef TOKDEC_CACHE_EN
  logic                  cvld_q, cvld_d;
  logic [ADDR_WIDTH-1:0] cidx_q, cidx_d;
  logic [ADDR_WIDTH-1:0] caddr_q, caddr_d;
  logic [ADDR_WIDTH-1:0] wstart_q, wstart_d;
`endif

  always_ff @(posedge blocker_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= START_A;
      cnt_q       <= '0;
      idx_q       <= '0;
      ch_data_q   <= '0;
      ch_last_q   <= 1'b0;
      err_nf_q    <= 1'b0;
      ch_valid_q  <= 1'b0;
      tok_ready_q <= 1'b1;
      mem_cs_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ch_data_q   <= ch_data_d;
      ch_last_q   <= ch_last_d;
      err_nf_q    <= err_nf_d;
      ch_valid_q  <= ch_valid_d;
      tok_ready_q <= tok_ready_d;
      mem_cs_q    <= mem_cs_d;
    end
  end

`ifdef TOKDEC_CACHE_EN
  always_ff @(posedge blocker_clk or negedge rst_n) begin
    if (!rst_n) begin
      cvld_q   <= 1'b0;
      cidx_q   <= '0;
      caddr_q  <= START_A;
      wstart_q <= START_A;
    end else begin
      cvld_q   <= cvld_d;
      cidx_q   <= cidx_d;
      caddr_q  <= caddr_d;
      wstart_q <= wstart_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ch_data_d = ch_data_q;
    ch_last_d = ch_last_q;
    err_nf_d  = err_nf_q;
    is_term   = (bus.mem_dout == TERM);
    at_end    = (addr_q == END_A);
    cnt_inc   = cnt_q + CNT_W'(1);
`ifdef TOKDEC_CACHE_EN
    cvld_d    = cvld_q;
    cidx_d    = cidx_q;
    caddr_d   = caddr_q;
    wstart_d  = wstart_q;
    cache_hit = cvld_q && (bus.tok_idx == cidx_q);
    hit_addr  = caddr_q;
`else
    cache_hit = 1'b0;
    hit_addr  = START_A;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.tok_valid) begin
          idx_d     = bus.tok_idx;
          cnt_d     = '0;
          ch_last_d = 1'b0;
          err_nf_d  = 1'b0;
          if (cache_hit) begin
            addr_d  = hit_addr;
            state_d = S_EMIT_RD;
          end else begin
            addr_d  = START_A;
            state_d = (bus.tok_idx == '0) ? S_EMIT_RD : S_SEEK_RD;
          end
        end
      end
      S_SEEK_RD: state_d = S_SEEK_CHK;
      S_SEEK_CHK: begin
        if (is_term) cnt_d = cnt_inc;
        // At END_ADDR nothing can follow, so even a match there is a miss.
        if (at_end) begin
          ch_data_d = TERM;
          ch_last_d = 1'b1;
          err_nf_d  = 1'b1;
          state_d   = S_EMIT_OUT;
        end else if (is_term && (cnt_inc == CNT_W'(idx_q))) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_EMIT_RD;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_SEEK_RD;
        end
      end
      S_EMIT_RD: state_d = S_EMIT_CHK;
      S_EMIT_CHK: begin
        // A word still running at END_ADDR is cut with an error terminator.
        if (!is_term && at_end) begin
          ch_data_d = TERM;
          ch_last_d = 1'b1;
          err_nf_d  = 1'b1;
        end else begin
          ch_data_d = bus.mem_dout;
          ch_last_d = is_term;
          err_nf_d  = 1'b0;
        end
        state_d = S_EMIT_OUT;
      end
      S_EMIT_OUT: begin
        if (bus.ch_ready) begin
          if (ch_last_q) begin
            state_d = S_IDLE;
`ifdef TOKDEC_CACHE_EN
            if (!err_nf_q) begin
              cvld_d  = 1'b1;
              cidx_d  = idx_q;
              caddr_d = wstart_q;
            end
`endif
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_EMIT_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef TOKDEC_CACHE_EN
    if ((state_d == S_EMIT_RD) && (state_q != S_EMIT_OUT)) wstart_d = addr_d;
`endif

    tok_ready_d = (state_d == S_IDLE);
    ch_valid_d  = (state_d == S_EMIT_OUT);
    mem_cs_d    = (state_d == S_SEEK_RD) || (state_d == S_EMIT_RD);
  end

  assign bus.tok_ready = tok_ready_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_addr  = addr_q;
  assign bus.ch_valid  = ch_valid_q;
  assign bus.ch_data   = ch_data_q;
  assign bus.ch_last   = ch_last_q;
  assign bus.err_nf    = err_nf_q;

endmodule

// File: tb/tb_token_decoder.sv
// Self-checking bench for token_decoder: SRAM model, reference word model and beat scoreboard.
module tb_token_decoder;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
  } beat_t;

`ifdef TOKDEC_CACHE_EN
  localparam int REP_LAT = 3;
`else
  localparam int REP_LAT = 9;
`endif

  logic blocker_clk;
  logic rst_n;
  int   cyc;
  int   rd_cnt;
  int   n_checks;
  int   n_fail;
  logic [7:0] vocab [16];
  beat_t exp_q[$];
  beat_t obs_q[$];

  token_decoder_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  token_decoder #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8),
    .START_ADDR(0),
    .END_ADDR  (15)
  ) dut (
    .blocker_clk(blocker_clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  initial begin
    blocker_clk = 1'b0;
    forever #5 blocker_clk = ~blocker_clk;
  end

  always @(posedge blocker_clk) begin
    cyc <= cyc + 1;
    if (bus.mem_cs === 1'b1) begin
      bus.mem_dout <= vocab[bus.mem_addr];
      rd_cnt       <= rd_cnt + 1;
    end
  end

  // Reference: locate word idx by counting terminators, then emit it.
  function automatic void push_expected(input int idx);
    int    a;
    int    cnt;
    beat_t b;
    a   = 0;
    cnt = 0;
    while (cnt < idx && a <= 15) begin
      if (vocab[a] == 8'h00) cnt++;
      a++;
    end
    if (cnt < idx || a > 15) begin
      b = '{data: 8'h00, last: 1'b1, err: 1'b1};
      exp_q.push_back(b);
      return;
    end
    forever begin
      if (vocab[a] == 8'h00) begin
        b = '{data: 8'h00, last: 1'b1, err: 1'b0};
        exp_q.push_back(b);
        return;
      end else if (a == 15) begin
        b = '{data: 8'h00, last: 1'b1, err: 1'b1};
        exp_q.push_back(b);
        return;
      end
      b = '{data: vocab[a], last: 1'b0, err: 1'b0};
      exp_q.push_back(b);
      a++;
    end
  endfunction

  task automatic drive_tok(input logic [3:0] idx, output int hs_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.tok_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge blocker_clk);
    end
    hs_cyc        = cyc;
    bus.tok_idx   = idx;
    bus.tok_valid = ok;
    @(negedge blocker_clk);
    bus.tok_valid = 1'b0;
  endtask

  task automatic collect(input int max_cyc, output int first_cyc, output bit done);
    beat_t b;
    first_cyc = -1;
    done      = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.ch_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (bus.ch_ready === 1'b1) begin
          b.data = bus.ch_data;
          b.last = bus.ch_last;
          b.err  = bus.err_nf;
          obs_q.push_back(b);
          if (b.last === 1'b1) begin
            done = 1'b1;
            break;
          end
        end
      end
      @(negedge blocker_clk);
    end
    if (done) @(negedge blocker_clk);
  endtask

  task automatic test_reset(input string name);
    rst_n         = 1'b0;
    bus.tok_valid = 1'b0;
    @(negedge blocker_clk);
    n_checks++;
    if (bus.tok_ready !== 1'b1) begin n_fail++; $display("FAIL %s tok_ready: got %b want 1", name, bus.tok_ready); end
    n_checks++;
    if (bus.ch_valid !== 1'b0) begin n_fail++; $display("FAIL %s ch_valid: got %b want 0", name, bus.ch_valid); end
    n_checks++;
    if (bus.ch_last !== 1'b0) begin n_fail++; $display("FAIL %s ch_last: got %b want 0", name, bus.ch_last); end
    n_checks++;
    if (bus.ch_data !== 8'h00) begin n_fail++; $display("FAIL %s ch_data: got %h want 00", name, bus.ch_data); end
    n_checks++;
    if (bus.err_nf !== 1'b0) begin n_fail++; $display("FAIL %s err_nf: got %b want 0", name, bus.err_nf); end
    n_checks++;
    if (bus.mem_cs !== 1'b0) begin n_fail++; $display("FAIL %s mem_cs: got %b want 0", name, bus.mem_cs); end
    n_checks++;
    if (bus.mem_addr !== 4'd0) begin n_fail++; $display("FAIL %s mem_addr: got %0d want 0", name, bus.mem_addr); end
    rst_n = 1'b1;
    @(negedge blocker_clk);
  endtask

  task automatic test_decode(input string name, input logic [3:0] idx, input int exp_lat);
    int    hs;
    int    first;
    bit    ok;
    bit    done;
    int    n;
    beat_t e;
    beat_t o;
    exp_q.delete();
    obs_q.delete();
    push_expected(int'(idx));
    drive_tok(idx, hs, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s handshake: tok_ready never high", name); end
    collect(200, first, done);
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL %s last beat: got none within 200 cycles, want one", name); end
    if (exp_lat >= 0) begin
      n_checks++;
      if (first - hs !== exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d cycles want %0d", name, first - hs, exp_lat);
      end
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s beat %0d: got nothing want data=%h last=%b err=%b", name, n, e.data, e.last, e.err);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s beat %0d: got data=%h last=%b err=%b want data=%h last=%b err=%b",
                   name, n, o.data, o.last, o.err, e.data, e.last, e.err);
        end
      end
      n++;
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL %s extra beats: got %0d want 0", name, obs_q.size()); end
    n_checks++;
    if (bus.tok_ready !== 1'b1) begin n_fail++; $display("FAIL %s tok_ready after last: got %b want 1", name, bus.tok_ready); end
  endtask

  task automatic test_stall();
    int    hs;
    int    first;
    int    rd0;
    bit    ok;
    bit    done;
    beat_t e;
    beat_t o;
    exp_q.delete();
    obs_q.delete();
    push_expected(1);
    bus.ch_ready = 1'b0;
    drive_tok(4'd1, hs, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall handshake: tok_ready never high"); end
    for (int i = 0; i < 50; i++) begin
      if (bus.ch_valid === 1'b1) break;
      @(negedge blocker_clk);
    end
    n_checks++;
    if (bus.ch_valid !== 1'b1) begin n_fail++; $display("FAIL stall first beat: ch_valid got %b want 1", bus.ch_valid); end
    rd0 = rd_cnt;
    repeat (4) begin
      @(negedge blocker_clk);
      n_checks++;
      if (bus.ch_valid !== 1'b1 || bus.ch_data !== 8'h43 || bus.ch_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stall hold: got valid=%b data=%h last=%b want 1/43/0", bus.ch_valid, bus.ch_data, bus.ch_last);
      end
    end
    n_checks++;
    if (rd_cnt !== rd0) begin n_fail++; $display("FAIL stall sram reads: got %0d extra want 0", rd_cnt - rd0); end
    bus.ch_ready = 1'b1;
    collect(50, first, done);
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL stall last beat: got none want one"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL stall beat: got nothing want data=%h last=%b", e.data, e.last);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL stall beat: got data=%h last=%b err=%b want data=%h last=%b err=%b",
                   o.data, o.last, o.err, e.data, e.last, e.err);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    bit ok;
    drive_tok(4'd3, hs, ok);
    repeat (16) @(negedge blocker_clk);
    n_checks++;
    if (bus.tok_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy: tok_ready got %b want 0", bus.tok_ready); end
    test_reset("reset_mid");
  endtask

  initial begin
    cyc           = 0;
    rd_cnt        = 0;
    n_checks      = 0;
    n_fail        = 0;
    bus.tok_valid = 1'b0;
    bus.tok_idx   = '0;
    bus.ch_ready  = 1'b1;
    bus.mem_dout  = '0;
    vocab[0] = 8'h41; vocab[1] = 8'h42; vocab[2] = 8'h00; vocab[3] = 8'h43;
    vocab[4] = 8'h00; vocab[5] = 8'h00; vocab[6] = 8'h44;
    for (int i = 7; i < 16; i++) vocab[i] = 8'h45;

    test_reset("reset");
    test_decode("idx0", 4'd0, 3);
    test_decode("idx1_seek", 4'd1, 9);
    test_decode("idx2_empty", 4'd2, -1);
    test_decode("idx3_overrun", 4'd3, -1);
    test_decode("idx9_notfound", 4'd9, -1);
    test_stall();
    test_reset_mid();
    test_decode("idx0_after_reset", 4'd0, 3);
    test_decode("idx1_first", 4'd1, 9);
    test_decode("idx1_repeat", 4'd1, REP_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
